// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT engine and its readout stage.
// Bin layout: [15:8] signed real, [7:0] signed imaginary.
package fft_pkg;

  localparam int FFT_POINTS = 4;

  localparam logic [7:0] FFT_HDR_BYTE = 8'hA5;

  localparam int RE_MSB = 15;
  localparam int RE_LSB = 8;
  localparam int IM_MSB = 7;
  localparam int IM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_RE   = 3'd2,
    ST_IM   = 3'd3,
    ST_MAG  = 3'd4
  } stream_state_t;

endpackage

// File: rtl/fft_mag_approx.sv
// Saturated |re|+|im| magnitude approximation.
// Combinational; |-128| is taken as 128 before the 9-bit sum.
module fft_mag_approx (
  input  logic [7:0] re,
  input  logic [7:0] im,
  output logic [7:0] mag
);

  logic [7:0] abs_re;
  logic [7:0] abs_im;
  logic [8:0] sum;

  always_comb begin
    abs_re = re[7] ? (~re + 8'd1) : re;
    abs_im = im[7] ? (~im + 8'd1) : im;
    sum    = {1'b0, abs_re} + {1'b0, abs_im};
    mag    = sum[8] ? 8'hFF : sum[7:0];
  end

endmodule

// File: rtl/fft_bin_streamer.sv
// Captures four FFT bins on fft_done and streams them out as
// header, re, im and optional magnitude bytes over valid/ready.
module fft_bin_streamer
  import fft_pkg::*;
#(
  parameter logic [7:0] HDR    = FFT_HDR_BYTE,
  parameter bit         MAG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        fft_done,
  input  logic [15:0] freq0,
  input  logic [15:0] freq1,
  input  logic [15:0] freq2,
  input  logic [15:0] freq3,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy,
  output logic        overflow,
  input  logic        ovf_clr
);

  stream_state_t state_q;
  stream_state_t state_d;
  logic [1:0]    bin_q;
  logic [1:0]    bin_d;
  logic [15:0]   frame_q [FFT_POINTS];
  logic          ovf_q;

  logic          hs;
  logic          last_byte;
  logic          capture;
  logic          ovf_set;
  logic [15:0]   cur;
  logic [7:0]    mag;

  always_comb begin
    cur       = frame_q[bin_q];
    last_byte = (MAG_EN ? (state_q == ST_MAG) : (state_q == ST_IM))
                && (bin_q == 2'd3);
    hs        = ena && out_valid && out_ready;
    // A pulse landing on the final handshake starts the next frame.
    capture   = ena && fft_done
                && ((state_q == ST_IDLE) || (hs && last_byte));
    ovf_set   = ena && fft_done && (state_q != ST_IDLE)
                && !(hs && last_byte);
  end

  fft_mag_approx u_mag (
    .re  (cur[RE_MSB:RE_LSB]),
    .im  (cur[IM_MSB:IM_LSB]),
    .mag (mag)
  );

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    if (capture) begin
      state_d = ST_HDR;
      bin_d   = 2'd0;
    end else if (hs) begin
      unique case (state_q)
        ST_HDR: state_d = ST_RE;
        ST_RE:  state_d = ST_IM;
        ST_IM: begin
          if (MAG_EN) begin
            state_d = ST_MAG;
          end else if (last_byte) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RE;
            bin_d   = bin_q + 2'd1;
          end
        end
        ST_MAG: begin
          if (last_byte) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RE;
            bin_d   = bin_q + 2'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= 2'd0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < FFT_POINTS; i++) begin
        frame_q[i] <= '0;
      end
    end else if (ena) begin
      state_q <= state_d;
      bin_q   <= bin_d;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
      if (capture) begin
        frame_q[0] <= freq0;
        frame_q[1] <= freq1;
        frame_q[2] <= freq2;
        frame_q[3] <= freq3;
      end
    end
  end

  always_comb begin
    out_data = 8'h00;
    unique case (state_q)
      ST_HDR:  out_data = HDR;
      ST_RE:   out_data = cur[RE_MSB:RE_LSB];
      ST_IM:   out_data = cur[IM_MSB:IM_LSB];
      ST_MAG:  out_data = mag;
      default: out_data = 8'h00;
    endcase
  end

  assign out_valid = (state_q != ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_last  = out_valid && last_byte;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fft_bin_streamer.sv
// Directed bench for fft_bin_streamer, MAG_EN=1 and MAG_EN=0 instances.
// Expected byte streams are hand-computed from the bin values.
module tb_fft_bin_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ena, ena0;
  logic        fft_done, done0;
  logic        ready, ready0;
  logic        ovf_clr;
  logic [15:0] f0, f1, f2, f3;

  logic       v1, l1, b1, o1;
  logic [7:0] d1;
  logic       v0, l0, b0, o0;
  logic [7:0] d0;

  fft_bin_streamer #(.HDR(8'hA5), .MAG_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .fft_done(fft_done),
    .freq0(f0), .freq1(f1), .freq2(f2), .freq3(f3),
    .out_ready(ready), .out_valid(v1), .out_data(d1), .out_last(l1),
    .busy(b1), .overflow(o1), .ovf_clr(ovf_clr)
  );

  fft_bin_streamer #(.HDR(8'hA5), .MAG_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena0), .fft_done(done0),
    .freq0(f0), .freq1(f1), .freq2(f2), .freq3(f3),
    .out_ready(ready0), .out_valid(v0), .out_data(d0), .out_last(l0),
    .busy(b0), .overflow(o0), .ovf_clr(1'b0)
  );

  typedef struct {
    logic [15:0]       b0, b1, b2, b3;
    logic [0:12][7:0]  bytes;
  } vec_t;

  vec_t vecs [3];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic capture(input int sel, input vec_t v);
    f0 = v.b0; f1 = v.b1; f2 = v.b2; f3 = v.b3;
    if (sel == 1) done0 = 1'b1;
    else fft_done = 1'b1;
    @(posedge clk); #1;
    fft_done = 1'b0;
    done0 = 1'b0;
    chk("cap_busy", sel == 1 ? b0 : b1, 1'b1);
  endtask

  task automatic stream(input int sel, input logic [0:12][7:0] exp,
                        input int n, input bit bp, input int inj,
                        input int drop_at, input bit b2b,
                        output int cyc);
    int idx;
    bit dropped;
    logic r;
    idx = 0; cyc = 0; dropped = 0;
    while (idx < n && cyc < 60) begin
      chk("valid", sel == 1 ? v0 : v1, 1'b1);
      chk("data", sel == 1 ? d0 : d1, exp[idx]);
      chk("last", sel == 1 ? l0 : l1, idx == n - 1);
      if (sel == 1 && idx == drop_at && !dropped) begin
        dropped = 1;
        ena0 = 1'b0; ready0 = 1'b1; done0 = 1'b1;
        repeat (3) begin
          @(posedge clk); #1;
          chk("frz_valid", v0, 1'b1);
          chk("frz_data", d0, exp[idx]);
          chk("frz_last", l0, idx == n - 1);
        end
        done0 = 1'b0; ena0 = 1'b1;
        chk("frz_ovf", o0, 1'b0);
      end
      r = bp ? ((cyc % 2) == 0) : 1'b1;
      if (sel == 1) ready0 = r;
      else ready = r;
      if (sel == 0 && idx == inj) begin
        fft_done = 1'b1;
        f0 = 16'h1111; f1 = 16'h1111; f2 = 16'h1111; f3 = 16'h1111;
      end else if (sel == 0 && b2b && idx == n - 1) begin
        fft_done = 1'b1;
        f0 = 16'h0102; f1 = 16'h0102; f2 = 16'h0102; f3 = 16'h0102;
      end
      @(posedge clk); #1;
      cyc++;
      fft_done = 1'b0;
      if (r) idx++;
    end
    if (idx < n) begin
      total++; bad++;
      $display("FAIL stream_timeout act=%0d exp=%0d", idx, n);
    end
    ready = 1'b1;
    ready0 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [0:12][7:0] b2b_bytes;
    logic [0:12][7:0] nomag_bytes;

    vecs[0] = '{16'h0AF6, 16'h0000, 16'h7F7F, 16'h8080,
                {8'hA5, 8'h0A, 8'hF6, 8'h14, 8'h00, 8'h00, 8'h00,
                 8'h7F, 8'h7F, 8'hFE, 8'h80, 8'h80, 8'hFF}};
    vecs[1] = '{16'h0102, 16'hFF01, 16'h81FF, 16'h4040,
                {8'hA5, 8'h01, 8'h02, 8'h03, 8'hFF, 8'h01, 8'h02,
                 8'h81, 8'hFF, 8'h80, 8'h40, 8'h40, 8'h80}};
    vecs[2] = '{16'h8000, 16'h0080, 16'h807F, 16'h1234,
                {8'hA5, 8'h80, 8'h00, 8'h80, 8'h00, 8'h80, 8'h80,
                 8'h80, 8'h7F, 8'hFF, 8'h12, 8'h34, 8'h46}};
    b2b_bytes = {8'hA5, 8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03,
                 8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03};
    nomag_bytes = {8'hA5, 8'h0A, 8'hF6, 8'h00, 8'h00, 8'h7F, 8'h7F,
                   8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};

    rst_n = 1'b0; ena = 1'b1; ena0 = 1'b1;
    fft_done = 1'b0; done0 = 1'b0;
    ready = 1'b0; ready0 = 1'b0; ovf_clr = 1'b0;
    f0 = '0; f1 = '0; f2 = '0; f3 = '0;
    #12;
    chk("rst_valid", v1, 1'b0);
    chk("rst_data", d1, 8'h00);
    chk("rst_last", l1, 1'b0);
    chk("rst_busy", b1, 1'b0);
    chk("rst_ovf", o1, 1'b0);
    chk("rst_valid0", v0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      capture(0, vecs[i]);
      stream(0, vecs[i].bytes, 13, 1'b0, -1, -1, 1'b0, cyc);
      chk("frame_cycles", 16'(cyc), 16'd13);
      chk("frame_end_valid", v1, 1'b0);
      chk("frame_end_busy", b1, 1'b0);
    end

    capture(0, vecs[0]);
    stream(0, vecs[0].bytes, 13, 1'b1, -1, -1, 1'b0, cyc);
    chk("bp_cycles", 16'(cyc), 16'd25);
    chk("bp_end_valid", v1, 1'b0);

    capture(0, vecs[0]);
    stream(0, vecs[0].bytes, 13, 1'b0, 5, -1, 1'b0, cyc);
    chk("ovf_set", o1, 1'b1);
    chk("ovf_end_valid", v1, 1'b0);
    @(posedge clk); #1;
    chk("ovf_sticky", o1, 1'b1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovf_clr", o1, 1'b0);

    capture(0, vecs[0]);
    stream(0, vecs[0].bytes, 13, 1'b0, -1, -1, 1'b1, cyc);
    chk("b2b_valid", v1, 1'b1);
    chk("b2b_data", d1, 8'hA5);
    chk("b2b_ovf", o1, 1'b0);
    chk("b2b_busy", b1, 1'b1);
    stream(0, b2b_bytes, 13, 1'b0, -1, -1, 1'b0, cyc);
    chk("b2b_end_valid", v1, 1'b0);

    capture(1, vecs[0]);
    stream(1, nomag_bytes, 9, 1'b0, -1, 4, 1'b0, cyc);
    chk("nomag_cycles", 16'(cyc), 16'd9);
    chk("nomag_end_valid", v0, 1'b0);
    chk("nomag_end_busy", b0, 1'b0);

    ready = 1'b1;
    capture(0, vecs[0]);
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_data", d1, vecs[0].bytes[7]);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", v1, 1'b0);
    chk("mid_rst_busy", b1, 1'b0);
    chk("mid_rst_data", d1, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", v1, 1'b0);
    capture(0, vecs[1]);
    stream(0, vecs[1].bytes, 13, 1'b0, -1, -1, 1'b0, cyc);
    chk("post_rst_end", v1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
